// File: rtl/video_pkg.sv
// Shared types and helpers for the raster timing generator: line/frame totals,
// the sync/blank bundle carried through the latency pipe, and latency limits.
package video_pkg;

    localparam int MAX_PIX_LATENCY = 8;

    // Syncs are active-low, blanks active-high; the idle value is "blanked, no sync".
    typedef struct packed {
        logic hblank;
        logic vblank;
        logic hsync;
        logic vsync;
    } sync_bundle_t;

    localparam sync_bundle_t SYNC_IDLE = '{hblank: 1'b1, vblank: 1'b1, hsync: 1'b1, vsync: 1'b1};

    function automatic int line_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/video_delay_line.sv
// ce-gated shift register that delays the sync/blank bundle by DEPTH pixel ticks.
// Every stage resets to the idle (blanked, sync inactive) bundle.
module video_delay_line
    import video_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  sync_bundle_t d,
    output sync_bundle_t q
);

    sync_bundle_t stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= SYNC_IDLE;
            end
        end else if (ce) begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// Raster counter, fetch-coordinate issue and latency-aligned sync/blank/RGB output.
// Optional interlace (alternating VTOTAL / VTOTAL+1 fields) with VIDEO_TIMING_INTERLACE_EN.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int H_ACTIVE    = 320,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 32,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 240,
    parameter int V_FP        = 4,
    parameter int V_SYNC      = 3,
    parameter int V_BP        = 15,
    parameter int CNT_W       = 10,
    parameter int PIX_LATENCY = 2,
    parameter int COLOR_DEPTH = 6
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   ce_pix,
    input  logic [COLOR_DEPTH-1:0] R_in,
    input  logic [COLOR_DEPTH-1:0] G_in,
    input  logic [COLOR_DEPTH-1:0] B_in,
    output logic [CNT_W-1:0]       hcnt,
    output logic [CNT_W-1:0]       vcnt,
    output logic                   fetch_de,
    output logic [COLOR_DEPTH-1:0] R,
    output logic [COLOR_DEPTH-1:0] G,
    output logic [COLOR_DEPTH-1:0] B,
    output logic                   HSync,
    output logic                   VSync,
    output logic                   hblank,
    output logic                   vblank,
    output logic                   frame_start,
    output logic                   field
);

    localparam int HTOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int VTOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (HTOTAL > (1 << CNT_W) - 1 || VTOTAL + 1 > (1 << CNT_W) - 1) begin : g_bad_cnt_w
        $error("video_timing_gen: HTOTAL or VTOTAL+1 does not fit in CNT_W");
    end
    if (PIX_LATENCY < 1 || PIX_LATENCY > MAX_PIX_LATENCY) begin : g_bad_latency
        $error("video_timing_gen: PIX_LATENCY out of range 1..MAX_PIX_LATENCY");
    end

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(HTOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(VTOTAL - 1);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic         h_wrap;
    logic         v_wrap;
    logic         vs_active;
    sync_bundle_t raw;
    sync_bundle_t dly;

`ifdef VIDEO_TIMING_INTERLACE_EN
    localparam logic [CNT_W-1:0] V_LAST_ODD = CNT_W'(VTOTAL);
    localparam logic [CNT_W-1:0] H_HALF     = CNT_W'(HTOTAL / 2);

    logic field_q;

    // Field 1 carries the extra line and shifts its vsync edges by half a line.
    assign v_wrap = (vcnt == (field_q ? V_LAST_ODD : V_LAST));
    assign field  = field_q;

    always_comb begin
        vs_active = 1'b0;
        if (field_q) begin
            vs_active = ((vcnt > VS_START) || (vcnt == VS_START && hcnt >= H_HALF)) &&
                        ((vcnt < VS_END)   || (vcnt == VS_END   && hcnt <  H_HALF));
        end else begin
            vs_active = (vcnt >= VS_START) && (vcnt < VS_END);
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            field_q <= 1'b0;
        end else if (ce_pix && h_wrap && v_wrap) begin
            field_q <= ~field_q;
        end
    end
`else
    assign v_wrap    = (vcnt == V_LAST);
    assign field     = 1'b0;
    assign vs_active = (vcnt >= VS_START) && (vcnt < VS_END);
`endif

    assign h_wrap   = (hcnt == H_LAST);
    assign fetch_de = (hcnt < H_ACT) && (vcnt < V_ACT);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            hcnt        <= '0;
            vcnt        <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= ce_pix && h_wrap && v_wrap;
            if (ce_pix) begin
                if (h_wrap) begin
                    hcnt <= '0;
                    vcnt <= v_wrap ? '0 : vcnt + CNT_W'(1);
                end else begin
                    hcnt <= hcnt + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        raw        = SYNC_IDLE;
        raw.hblank = (hcnt >= H_ACT);
        raw.vblank = (vcnt >= V_ACT);
        raw.hsync  = ~((hcnt >= HS_START) && (hcnt < HS_END));
        raw.vsync  = ~vs_active;
    end

    video_delay_line #(
        .DEPTH (PIX_LATENCY)
    ) u_delay (
        .clk (clk_sys),
        .rst (reset),
        .ce  (ce_pix),
        .d   (raw),
        .q   (dly)
    );

    // The source's pixel for the delayed coordinate is on R_in/G_in/B_in this tick.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            R      <= '0;
            G      <= '0;
            B      <= '0;
            HSync  <= 1'b1;
            VSync  <= 1'b1;
            hblank <= 1'b1;
            vblank <= 1'b1;
        end else if (ce_pix) begin
            HSync  <= dly.hsync;
            VSync  <= dly.vsync;
            hblank <= dly.hblank;
            vblank <= dly.vblank;
            if (dly.hblank || dly.vblank) begin
                R <= '0;
                G <= '0;
                B <= '0;
            end else begin
                R <= R_in;
                G <= G_in;
                B <= B_in;
            end
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized scoreboard bench for video_timing_gen against a frame-position model
// (small raster so several whole frames fit; VIDEO_TIMING_INTERLACE_EN also honoured).
module tb_video_timing_gen;

    localparam int HA  = 20;
    localparam int HFP = 3;
    localparam int HSW = 4;
    localparam int HBP = 5;
    localparam int VA  = 10;
    localparam int VFP = 2;
    localparam int VSW = 3;
    localparam int VBP = 4;
    localparam int CW  = 10;
    localparam int LAT = 2;
    localparam int CD  = 6;
    localparam int HT  = HA + HFP + HSW + HBP;
    localparam int VT  = VA + VFP + VSW + VBP;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          ce_pix;
    logic [CD-1:0] R_in, G_in, B_in;
    logic [CW-1:0] hcnt, vcnt;
    logic          fetch_de;
    logic [CD-1:0] R, G, B;
    logic          HSync, VSync, hblank, vblank, frame_start, field;

    video_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
        .CNT_W (CW), .PIX_LATENCY (LAT), .COLOR_DEPTH (CD)
    ) dut (
        .clk_sys (clk_sys), .reset (reset), .ce_pix (ce_pix),
        .R_in (R_in), .G_in (G_in), .B_in (B_in),
        .hcnt (hcnt), .vcnt (vcnt), .fetch_de (fetch_de),
        .R (R), .G (G), .B (B),
        .HSync (HSync), .VSync (VSync), .hblank (hblank), .vblank (vblank),
        .frame_start (frame_start), .field (field)
    );

    // clock / reset
    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int hcnt; int vcnt; int de; int field; int fs;
        int hb; int vb; int hs; int vs; int r; int g; int b;
    } exp_t;

    exp_t exp_q[$];
    exp_t last;
    int   n_cmp = 0;
    int   n_err = 0;
    int   k     = 0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    // Counter position after m pixel ticks since reset release.
    function automatic void coord(input int m, output int x, output int y, output int f);
        int r;
`ifdef VIDEO_TIMING_INTERLACE_EN
        r = m % (HT * (2 * VT + 1));
        f = 0;
        if (r >= HT * VT) begin
            r = r - HT * VT;
            f = 1;
        end
`else
        r = m % (HT * VT);
        f = 0;
`endif
        x = r % HT;
        y = r / HT;
    endfunction

    function automatic exp_t model(input int kk, input int r, input int g, input int b);
        exp_t e;
        int x, y, f, p, vs_lo;
        coord(kk, x, y, f);
        e.hcnt  = x;
        e.vcnt  = y;
        e.field = f;
        e.de    = (x < HA && y < VA) ? 1 : 0;
        e.fs    = (kk > 0 && x == 0 && y == 0) ? 1 : 0;
        if (kk - LAT - 1 < 0) begin
            e.hb = 1; e.vb = 1; e.hs = 1; e.vs = 1;
            e.r = 0; e.g = 0; e.b = 0;
        end else begin
            coord(kk - LAT - 1, x, y, f);
            e.hb = (x >= HA) ? 1 : 0;
            e.vb = (y >= VA) ? 1 : 0;
            e.hs = (x >= HA + HFP && x < HA + HFP + HSW) ? 0 : 1;
            if (f == 1) begin
                p     = y * HT + x;
                vs_lo = (p >= (VA + VFP) * HT + HT / 2 && p < (VA + VFP + VSW) * HT + HT / 2) ? 1 : 0;
            end else begin
                vs_lo = (y >= VA + VFP && y < VA + VFP + VSW) ? 1 : 0;
            end
            e.vs = vs_lo ? 0 : 1;
            if (e.hb == 1 || e.vb == 1) begin
                e.r = 0; e.g = 0; e.b = 0;
            end else begin
                e.r = r; e.g = g; e.b = b;
            end
        end
        return e;
    endfunction

    // driver
    task automatic step(input bit ce);
        @(negedge clk_sys);
        ce_pix = ce;
        R_in   = CD'($urandom_range(0, (1 << CD) - 1));
        G_in   = CD'($urandom_range(0, (1 << CD) - 1));
        B_in   = CD'($urandom_range(0, (1 << CD) - 1));
        if (ce) begin
            k++;
            last = model(k, int'(R_in), int'(G_in), int'(B_in));
        end else begin
            last.fs = 0;
        end
        exp_q.push_back(last);
    endtask

    task automatic drain();
        int budget = 10;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk_sys);
            budget--;
        end
        #2;
        check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_hcnt"}, int'(hcnt), 0);
        check({tag, "_vcnt"}, int'(vcnt), 0);
        check({tag, "_fetch_de"}, int'(fetch_de), 1);
        check({tag, "_rgb"}, int'({R, G, B}), 0);
        check({tag, "_hsync"}, int'(HSync), 1);
        check({tag, "_vsync"}, int'(VSync), 1);
        check({tag, "_hblank"}, int'(hblank), 1);
        check({tag, "_vblank"}, int'(vblank), 1);
        check({tag, "_frame_start"}, int'(frame_start), 0);
        check({tag, "_field"}, int'(field), 0);
    endtask

    // monitor / scoreboard
    always @(posedge clk_sys) begin
        exp_t e;
        #1;
        if (!reset && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("hcnt", int'(hcnt), e.hcnt);
            check("vcnt", int'(vcnt), e.vcnt);
            check("fetch_de", int'(fetch_de), e.de);
            check("field", int'(field), e.field);
            check("frame_start", int'(frame_start), e.fs);
            check("hblank", int'(hblank), e.hb);
            check("vblank", int'(vblank), e.vb);
            check("HSync", int'(HSync), e.hs);
            check("VSync", int'(VSync), e.vs);
            check("R", int'(R), e.r);
            check("G", int'(G), e.g);
            check("B", int'(B), e.b);
        end
    end

    initial begin
        reset  = 1'b1;
        ce_pix = 1'b0;
        R_in   = '0;
        G_in   = '0;
        B_in   = '0;
        repeat (3) @(negedge clk_sys);
        check_reset_values("por");
        reset  = 1'b0;
        k      = 0;
        last   = model(0, 0, 0, 0);

        // random ce density
        for (int i = 0; i < 1400; i++) step($urandom_range(0, 2) != 0);
        // ce on every 4th clock
        for (int i = 0; i < 2800; i++) step((i % 4) == 0);
        // long ce-low hold, then continue
        for (int i = 0; i < 50; i++) step(1'b0);
        for (int i = 0; i < 300; i++) step($urandom_range(0, 3) != 0);
        drain();

        // asynchronous reset mid-frame with ce held high
        @(negedge clk_sys);
        ce_pix = 1'b1;
        #2 reset = 1'b1;
        #1 check_reset_values("async_rst");
        repeat (2) @(negedge clk_sys);
        reset  = 1'b0;
        ce_pix = 1'b0;
        k      = 0;
        last   = model(0, 0, 0, 0);

        for (int i = 0; i < 1500; i++) step($urandom_range(0, 4) != 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
